// File: rtl/crc16_pkg.sv
// rtl/crc16_pkg.sv - shared CRC-16/XMODEM constants and checker FSM states
package crc16_pkg;

    localparam logic [15:0] CRC_POLY      = 16'h1021;
    localparam logic [15:0] CRC_INIT      = 16'h0000;
    localparam int unsigned MIN_FRAME_LEN = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/crc16_byte_step.sv
// rtl/crc16_byte_step.sv - combinational CRC-16 update of one byte, MSB first
module crc16_byte_step
    import crc16_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] crc_v;

    always_comb begin
        crc_v = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (crc_v[15]) begin
                crc_v = {crc_v[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_v = {crc_v[14:0], 1'b0};
            end
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/crc16_checker.sv
// rtl/crc16_checker.sv - frame CRC-16/XMODEM checker with length and residue verdict
module crc16_checker
    import crc16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        data_valid,
    input  logic        sof,
    input  logic        eof,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic [15:0] byte_cnt,
    output logic [15:0] crc_calc
);

    state_e      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] step_in, step_out;
    logic        len_short;

    // A sof byte always restarts from the init value, even mid-frame.
    assign step_in = sof ? CRC_INIT : crc_q;

    crc16_byte_step u_step (
        .crc_in  (step_in),
        .data    (data),
        .crc_out (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            crc_q   <= CRC_INIT;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (data_valid && sof) begin
                    crc_d   = step_out;
                    cnt_d   = 16'd1;
                    state_d = eof ? ST_REPORT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (data_valid) begin
                    crc_d = step_out;
                    if (sof) begin
                        cnt_d = 16'd1;
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (eof) begin
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are gated by rst so the reset cycle itself already looks idle.
    assign len_short = (cnt_q < 16'(MIN_FRAME_LEN));
    assign in_ready  = !rst && (state_q != ST_REPORT);
    assign busy      = !rst && (state_q == ST_RUN);
    assign done      = !rst && (state_q == ST_REPORT);
    assign len_err   = done && len_short;
    assign crc_ok    = done && !len_short && (crc_q == 16'h0000);
    assign crc_err   = done && !len_short && (crc_q != 16'h0000);
    assign byte_cnt  = rst ? 16'd0 : cnt_q;
    assign crc_calc  = rst ? CRC_INIT : crc_q;

endmodule

// File: tb/tb_crc16_checker.sv
// tb/tb_crc16_checker.sv - scoreboard bench for crc16_checker with a frame-level model
module tb_crc16_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        data_valid, sof, eof;
    logic        in_ready, busy, done, crc_ok, crc_err, len_err;
    logic [15:0] byte_cnt, crc_calc;

    crc16_checker dut (
        .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
        .sof(sof), .eof(eof), .in_ready(in_ready), .busy(busy), .done(done),
        .crc_ok(crc_ok), .crc_err(crc_err), .len_err(len_err),
        .byte_cnt(byte_cnt), .crc_calc(crc_calc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ok;
        bit err;
        bit len;
        int cnt;
    } verdict_t;

    verdict_t   exp_q[$];
    verdict_t   v;
    logic [7:0] cur[$];
    logic [7:0] f[$];
    int         m_cnt;
    bit         m_active, m_report;
    int         checks, failures;
    int         tries;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial long division of the message by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_ref(input logic [7:0] msg[$]);
        logic [15:0] rem = 16'h0000;
        logic        fb;
        for (int i = 0; i < msg.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb  = rem[15] ^ msg[i][b];
                rem = {rem[14:0], 1'b0};
                if (fb) rem = rem ^ 16'h1021;
            end
        end
        return rem;
    endfunction

    task automatic model_accept(input logic [7:0] d, input bit s, input bit e);
        verdict_t nv;
        if (s) begin
            cur.delete();
            cur.push_back(d);
            m_cnt    = 1;
            m_active = 1;
        end else if (m_active) begin
            cur.push_back(d);
            if (m_cnt < 65535) m_cnt++;
        end else begin
            return;
        end
        if (e) begin
            nv.len = (m_cnt < 3);
            nv.ok  = !nv.len && (crc_ref(cur) == 16'h0000);
            nv.err = !nv.len && !nv.ok;
            nv.cnt = m_cnt;
            exp_q.push_back(nv);
            m_active = 0;
            m_report = 1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit s, input bit e, output int n);
        bit acc;
        data = d; sof = s; eof = e; data_valid = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            n++;
            acc = !m_report;
            @(posedge clk); #1;
            if (acc) begin
                model_accept(d, s, e);
                break;
            end
            m_report = 0;
        end
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0; sof = 1'b0; eof = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            m_report = 0;
        end
    endtask

    task automatic do_reset();
        data_valid = 1'b0; sof = 1'b0; eof = 1'b0;
        rst = 1'b1;
        cur.delete();
        m_cnt = 0; m_active = 0; m_report = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // gap < 0 picks a random 0..3 idle cycles after each byte.
    task automatic send_frame(input int gap, output int first_tries);
        int t, g;
        first_tries = 0;
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], i == 0, i == f.size() - 1, t);
            if (i == 0) first_tries = t;
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            if (g > 0) idle(g);
        end
    endtask

    task automatic make_good(input int n);
        logic [15:0] c;
        f.delete();
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
        c = crc_ref(f);
        f.push_back(c[15:8]);
        f.push_back(c[7:0]);
    endtask

    task automatic make_vector(input logic [7:0] last);
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31};
        f.push_back(last);
    endtask

    always @(negedge clk) begin
        check("in_ready", in_ready, !rst && !m_report);
        check("busy", busy, !rst && m_active);
        check("byte_cnt", byte_cnt, m_cnt);
        check("crc_calc", crc_calc, crc_ref(cur));
        check("done", done, !rst && m_report);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                v = exp_q.pop_front();
                check("verdict_ok", crc_ok, v.ok);
                check("verdict_err", crc_err, v.err);
                check("verdict_len", len_err, v.len);
                check("verdict_cnt", byte_cnt, v.cnt);
            end
        end else begin
            check("verdict_idle", {crc_ok, crc_err, len_err}, 3'b000);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, t;
        checks = 0; failures = 0;
        m_cnt = 0; m_active = 0; m_report = 0;
        data = 8'h00; data_valid = 1'b0; sof = 1'b0; eof = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        do_reset();
        idle(1);

        // Standard check vector, residue probed after the ninth byte.
        make_vector(8'hC3);
        for (int i = 0; i < 9; i++) send_byte(f[i], i == 0, 1'b0, t);
        @(negedge clk);
        check("xmodem_vector", crc_calc, 16'h31C3);
        send_byte(8'h31, 1'b0, 1'b0, t);
        send_byte(8'hC3, 1'b0, 1'b1, t);
        idle(2);

        make_vector(8'hC2);
        send_frame(0, t);
        idle(2);

        f = '{8'hAA, 8'h55};
        send_frame(0, t);
        idle(2);

        make_vector(8'hC3);
        send_frame(3, t);
        idle(1);

        // Abort after four bytes by starting a fresh frame.
        for (int i = 0; i < 4; i++) send_byte(f[i], i == 0, 1'b0, t);
        send_frame(0, t);
        idle(2);

        for (int i = 0; i < 4; i++) send_byte(f[i], i == 0, 1'b0, t);
        do_reset();
        send_frame(0, t);
        idle(2);

        // Back-to-back: the first byte of frame two is offered during REPORT.
        make_good(5);
        send_frame(0, t);
        make_good(4);
        send_frame(0, t);
        check("b2b_stall_tries", t, 2);
        idle(2);

        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 5);
            make_good($urandom_range(1, 10));
            case (kind)
                1: f[$urandom_range(0, f.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
                2: while (f.size() > $urandom_range(1, 2)) void'(f.pop_back());
                3: for (int j = 0; j < 3; j++) send_byte(8'($urandom), 1'b0, 1'($urandom), t);
                4: for (int j = 0; j < 3; j++) send_byte(8'($urandom), j == 0, 1'b0, t);
                5: begin
                    for (int j = 0; j < 2; j++) send_byte(8'($urandom), j == 0, 1'b0, t);
                    do_reset();
                end
                default: ;
            endcase
            send_frame(-1, t);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(4);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
